// File: rtl/mux_nx1_reg.sv
// N-channel, W-bit selector with a one-slot registered output and valid/ready handshakes.
// Grants either a fixed channel (mode=0) or a fair round-robin winner (mode=1).
module mux_nx1_reg #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0]    ptr_q;
    logic [WIDTH-1:0]    out_data_q;
    logic [SEL_W-1:0]    out_chan_q;
    logic                out_valid_q;

    logic [CHANNELS-1:0] fixed_onehot;
    logic [CHANNELS-1:0] hi_mask;
    logic [CHANNELS-1:0] hi_req;
    logic [CHANNELS-1:0] lo_req;
    logic [CHANNELS:0]   hi_seen;
    logic [CHANNELS:0]   lo_seen;
    logic [CHANNELS-1:0] hi_first;
    logic [CHANNELS-1:0] lo_first;
    logic [CHANNELS-1:0] rr_onehot;
    logic [CHANNELS-1:0] grant_onehot;

    logic [SEL_W-1:0]    idx_acc  [CHANNELS+1];
    logic [WIDTH-1:0]    data_acc [CHANNELS+1];

    logic                grant_vld;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic                can_load;
    logic                xfer;

    assign hi_seen[0]  = 1'b0;
    assign lo_seen[0]  = 1'b0;
    assign idx_acc[0]  = '0;
    assign data_acc[0] = '0;

    // Round-robin splits requesters into those at/after ptr (searched first) and those before it;
    // the lowest set bit of each half is found with a prefix-OR chain.
    for (genvar g = 0; g < CHANNELS; g++) begin : gen_chan
        assign fixed_onehot[g] = (sel == SEL_W'(g)) & in_valid[g];
        assign hi_mask[g]      = (SEL_W'(g) >= ptr_q);
        assign hi_req[g]       = in_valid[g] & hi_mask[g];
        assign lo_req[g]       = in_valid[g] & ~hi_mask[g];
        assign hi_seen[g+1]    = hi_seen[g] | hi_req[g];
        assign lo_seen[g+1]    = lo_seen[g] | lo_req[g];
        assign hi_first[g]     = hi_req[g] & ~hi_seen[g];
        assign lo_first[g]     = lo_req[g] & ~lo_seen[g];
        assign idx_acc[g+1]    = idx_acc[g] | (grant_onehot[g] ? SEL_W'(g) : '0);
        assign data_acc[g+1]   = data_acc[g] |
                                 (grant_onehot[g] ? in_data[g*WIDTH +: WIDTH] : '0);
    end

    always_comb begin
        rr_onehot    = hi_seen[CHANNELS] ? hi_first : lo_first;
        grant_onehot = mode ? rr_onehot : fixed_onehot;
        grant_vld    = |grant_onehot;
        grant_idx    = idx_acc[CHANNELS];
        grant_data   = data_acc[CHANNELS];
        can_load     = ~out_valid_q | out_ready;
        // Handshakes are suppressed during reset so nothing in flight is accepted.
        xfer         = grant_vld & can_load & ~reset;
        in_ready     = grant_onehot & {CHANNELS{can_load & ~reset}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
                out_chan_q  <= grant_idx;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (xfer && mode) begin
                ptr_q <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Bench for mux_nx1_reg: an 8-channel and a 5-channel instance, checked against hand vectors
// and a queue-free reference model that scans channels with modulo arithmetic.
module tb_mux_nx1_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, mode_a, out_valid_a, out_ready_a;
    logic [63:0] in_data_a;
    logic [7:0]  in_valid_a, in_ready_a, out_data_a;
    logic [2:0]  sel_a, out_chan_a;

    logic        reset_b, mode_b, out_valid_b, out_ready_b;
    logic [39:0] in_data_b;
    logic [4:0]  in_valid_b, in_ready_b;
    logic [7:0]  out_data_b;
    logic [2:0]  sel_b, out_chan_b;

    mux_nx1_reg #(.WIDTH(8), .CHANNELS(8)) dut_a (
        .clk(clk), .reset(reset_a), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .mode(mode_a), .sel(sel_a), .out_data(out_data_a),
        .out_chan(out_chan_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    mux_nx1_reg #(.WIDTH(8), .CHANNELS(5)) dut_b (
        .clk(clk), .reset(reset_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .mode(mode_b), .sel(sel_b), .out_data(out_data_b),
        .out_chan(out_chan_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [2:0] ch;
        int         ptr;
    } model_t;

    typedef struct {
        logic       rst;
        logic       md;
        logic [2:0] sl;
        logic [7:0] vld;
        logic       ordy;
        logic [7:0] rdy;
        logic       ov;
        logic [7:0] od;
        logic [2:0] oc;
    } vec_t;

    int     n_checks = 0;
    int     n_err    = 0;
    model_t ma, mb;
    vec_t   tbl [13];

    localparam logic [63:0] DIN = 64'hA9A8A7A6A5A4A3A2;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // One clock of the slot/arbiter behaviour, straight from the rules.
    function automatic void model_step(input int nch, input model_t s, input logic rst,
                                       input logic [63:0] din, input logic [7:0] vld,
                                       input logic md, input logic [2:0] sl, input logic ordy,
                                       output logic [7:0] rdy, output model_t ns);
        int         g;
        bit         can;
        logic [7:0] vs;
        g   = -1;
        ns  = s;
        rdy = 8'h00;
        if (rst) begin
            ns = '{v: 1'b0, d: 8'h00, ch: 3'd0, ptr: 0};
            return;
        end
        can = !s.v || ordy;
        if (!md) begin
            vs = vld >> sl;
            if (int'(sl) < nch && vs[0]) g = int'(sl);
        end else begin
            for (int k = 0; k < nch; k++) begin
                int c;
                c  = (s.ptr + k) % nch;
                vs = vld >> c;
                if (vs[0]) begin
                    g = c;
                    break;
                end
            end
        end
        if (g >= 0 && can) begin
            rdy   = 8'd1 << g;
            ns.v  = 1'b1;
            ns.d  = 8'(din >> (8 * g));
            ns.ch = 3'(g);
            if (md) ns.ptr = (g + 1) % nch;
        end else if (ordy) begin
            ns.v = 1'b0;
        end
    endfunction

    task automatic step_a(input logic rst, input logic md, input logic [2:0] sl,
                          input logic [7:0] vld, input logic ordy, input logic [63:0] din);
        logic [7:0] rdy_e;
        model_t     nx;
        reset_a = rst; mode_a = md; sel_a = sl; in_valid_a = vld;
        out_ready_a = ordy; in_data_a = din;
        #2;
        model_step(8, ma, rst, din, vld, md, sl, ordy, rdy_e, nx);
        chk("a_in_ready", 64'(in_ready_a), 64'(rdy_e));
        chk("a_out_valid", 64'(out_valid_a), 64'(ma.v));
        chk("a_out_data", 64'(out_data_a), 64'(ma.d));
        chk("a_out_chan", 64'(out_chan_a), 64'(ma.ch));
        @(posedge clk);
        #1;
        ma = nx;
    endtask

    task automatic step_b(input logic rst, input logic md, input logic [2:0] sl,
                          input logic [7:0] vld, input logic ordy, input logic [63:0] din);
        logic [7:0] rdy_e;
        model_t     nx;
        reset_b = rst; mode_b = md; sel_b = sl; in_valid_b = vld[4:0];
        out_ready_b = ordy; in_data_b = din[39:0];
        #2;
        model_step(5, mb, rst, {24'b0, din[39:0]}, {3'b0, vld[4:0]}, md, sl, ordy, rdy_e, nx);
        chk("b_in_ready", 64'(in_ready_b), 64'(rdy_e));
        chk("b_out_valid", 64'(out_valid_b), 64'(mb.v));
        chk("b_out_data", 64'(out_data_b), 64'(mb.d));
        chk("b_out_chan", 64'(out_chan_b), 64'(mb.ch));
        @(posedge clk);
        #1;
        mb = nx;
    endtask

    initial begin
        ma = '{v: 1'b0, d: 8'h00, ch: 3'd0, ptr: 0};
        mb = '{v: 1'b0, d: 8'h00, ch: 3'd0, ptr: 0};
        reset_a = 1'b1; mode_a = 1'b0; sel_a = 3'd0; in_valid_a = 8'h00;
        out_ready_a = 1'b0; in_data_a = 64'h0;
        reset_b = 1'b1; mode_b = 1'b0; sel_b = 3'd0; in_valid_b = 5'h00;
        out_ready_b = 1'b0; in_data_b = 40'h0;

        //            rst   md    sel   vld    ordy  rdy    ov    od     oc (after edge)
        tbl[0]  = '{1'b1, 1'b0, 3'd3, 8'h08, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0};
        tbl[1]  = '{1'b0, 1'b0, 3'd3, 8'h08, 1'b1, 8'h08, 1'b1, 8'hA5, 3'd3};
        tbl[2]  = '{1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 3'd3};
        tbl[3]  = '{1'b0, 1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 8'hA7, 3'd5};
        tbl[4]  = '{1'b0, 1'b0, 3'd5, 8'h00, 1'b1, 8'h00, 1'b0, 8'hA7, 3'd5};
        tbl[5]  = '{1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA7, 3'd5};
        tbl[6]  = '{1'b0, 1'b1, 3'd0, 8'h84, 1'b0, 8'h04, 1'b1, 8'hA4, 3'd2};
        tbl[7]  = '{1'b0, 1'b1, 3'd0, 8'h84, 1'b1, 8'h80, 1'b1, 8'hA9, 3'd7};
        tbl[8]  = '{1'b0, 1'b1, 3'd0, 8'h84, 1'b1, 8'h04, 1'b1, 8'hA4, 3'd2};
        tbl[9]  = '{1'b0, 1'b1, 3'd0, 8'h84, 1'b1, 8'h80, 1'b1, 8'hA9, 3'd7};
        tbl[10] = '{1'b0, 1'b1, 3'd0, 8'h84, 1'b0, 8'h00, 1'b1, 8'hA9, 3'd7};
        tbl[11] = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0};
        tbl[12] = '{1'b0, 1'b1, 3'd0, 8'hF0, 1'b1, 8'h10, 1'b1, 8'hA6, 3'd4};

        for (int r = 0; r < 13; r++) begin
            logic [7:0] rdy_m;
            model_t     nx;
            reset_a = tbl[r].rst; mode_a = tbl[r].md; sel_a = tbl[r].sl;
            in_valid_a = tbl[r].vld; out_ready_a = tbl[r].ordy; in_data_a = DIN;
            #2;
            model_step(8, ma, tbl[r].rst, DIN, tbl[r].vld, tbl[r].md, tbl[r].sl,
                       tbl[r].ordy, rdy_m, nx);
            chk($sformatf("tbl%0d_in_ready", r), 64'(in_ready_a), 64'(tbl[r].rdy));
            @(posedge clk);
            #1;
            ma = nx;
            chk($sformatf("tbl%0d_out_valid", r), 64'(out_valid_a), 64'(tbl[r].ov));
            chk($sformatf("tbl%0d_out_data", r), 64'(out_data_a), 64'(tbl[r].od));
            chk($sformatf("tbl%0d_out_chan", r), 64'(out_chan_a), 64'(tbl[r].oc));
        end

        // Backpressure: hold a word for 4 cycles, then pop and reload together.
        step_a(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, DIN);
        step_a(1'b0, 1'b0, 3'd3, 8'h08, 1'b1, DIN);
        for (int k = 0; k < 4; k++) step_a(1'b0, 1'b0, 3'd3, 8'hFF, 1'b0, {$urandom, $urandom});
        step_a(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, DIN);
        chk("bp_reload_valid", 64'(out_valid_a), 64'd1);
        chk("bp_reload_chan", 64'(out_chan_a), 64'd0);

        // Round-robin fairness from reset with every channel valid.
        step_a(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, DIN);
        for (int k = 0; k < 9; k++) begin
            step_a(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, DIN);
            chk("rr_chan_a", 64'(out_chan_a), 64'(k % 8));
        end

        // Reset while a word is held and a transfer is pending.
        step_a(1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, DIN);
        step_a(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, DIN);
        chk("rst_mid_valid", 64'(out_valid_a), 64'd0);
        chk("rst_mid_data", 64'(out_data_a), 64'd0);
        step_a(1'b0, 1'b1, 3'd0, 8'h30, 1'b1, DIN);
        chk("rst_first_grant", 64'(out_chan_a), 64'd4);

        for (int k = 0; k < 400; k++) begin
            step_a(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                   {$urandom, $urandom});
        end

        // Five-channel instance: out-of-range select, then round-robin wrap at 5.
        step_b(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, DIN);
        step_b(1'b0, 1'b0, 3'd6, 8'h1F, 1'b1, DIN);
        step_b(1'b0, 1'b0, 3'd6, 8'h1F, 1'b1, DIN);
        chk("b_sel6_no_xfer", 64'(out_valid_b), 64'd0);
        for (int k = 0; k < 6; k++) begin
            step_b(1'b0, 1'b1, 3'd0, 8'h1F, 1'b1, DIN);
            chk("rr_chan_b", 64'(out_chan_b), 64'(k % 5));
        end
        for (int k = 0; k < 300; k++) begin
            step_b(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                   {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
